// File: rtl/seg_pkg.sv
// Shared constants for the segment scan driver: font selectors, the HEX7 glyph table and
// the blank pattern.
package seg_pkg;

  localparam int unsigned MODE_HEX7  = 0;
  localparam int unsigned MODE_INDEX = 1;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // gfedcba, indexed by nibble value
  localparam logic [6:0] HEX7_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_driver_if.sv
// Frame load port: valid/ready handshake carrying one nibble and one decimal point per digit.
interface seg_scan_driver_if #(
  parameter int unsigned DIGITS = 4
);

  logic                  load_valid;
  logic                  load_ready;
  logic [4*DIGITS-1:0]   load_data;
  logic [DIGITS-1:0]     load_dp;

  modport master (
    output load_valid,
    output load_data,
    output load_dp,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_dp,
    output load_ready
  );

endinterface

// File: rtl/seg_font.sv
// Combinational glyph decoder: nibble and decimal point to an 8-bit segment pattern.
module seg_font
  import seg_pkg::*;
#(
  parameter int unsigned MODE = MODE_HEX7
) (
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] pattern
);

  generate
    if (MODE == MODE_INDEX) begin : g_index
      // Index glyph is nibble + 1 in five bits, so F encodes as 16.
      assign pattern = {dp, 2'b00, {1'b0, nibble} + 5'd1};
    end else begin : g_hex7
      assign pattern = {dp, HEX7_FONT[nibble]};
    end
  endgenerate

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed LED digit scanner with double-buffered frame loads committed at frame end
// and 4-bit PWM gating of the digit enables.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned DIV_LOG2 = 10,
  parameter int unsigned MODE     = MODE_HEX7
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  load,
  input  logic [3:0]        brightness,
  output logic [7:0]        seg,
  output logic [DIGITS-1:0] dig_en,
  output logic              frame_tick
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);

  logic [DIV_LOG2-1:0] pre_q;
  logic [IdxW-1:0]     idx_q;
  logic                pending_q, pending_d;
  logic                shown_q, shown_d;
  logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d, active_data_q, active_data_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d, active_dp_q, active_dp_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   dig_en_q, dig_en_d;

  logic       frame_end, xfer, commit, bright_on;
  logic [3:0] cur_nibble;
  logic       cur_dp;
  logic [7:0] glyph;

  assign frame_end = (pre_q == '1) && (idx_q == IdxLast);
  assign xfer      = load.load_valid && !pending_q;
  assign commit    = frame_end && pending_q;
  assign bright_on = pre_q[DIV_LOG2-1 -: 4] <= brightness;

  assign cur_nibble = active_data_q[{idx_q, 2'b00} +: 4];
  assign cur_dp     = active_dp_q[idx_q];

  seg_font #(
    .MODE (MODE)
  ) u_font (
    .nibble  (cur_nibble),
    .dp      (cur_dp),
    .pattern (glyph)
  );

  always_comb begin
    pending_d     = pending_q;
    shown_d       = shown_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    // Commit and transfer are exclusive: load_ready is low whenever a commit can fire.
    if (commit) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
      pending_d     = 1'b0;
      shown_d       = 1'b1;
    end else if (xfer) begin
      shadow_data_d = load.load_data;
      shadow_dp_d   = load.load_dp;
      pending_d     = 1'b1;
    end
  end

  always_comb begin
    seg_d    = SEG_BLANK;
    dig_en_d = '0;
    if (shown_q) begin
      seg_d = glyph;
      if (bright_on) begin
        dig_en_d = DIGITS'(1) << idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q         <= '0;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      shown_q       <= 1'b0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      active_data_q <= '0;
      active_dp_q   <= '0;
      seg_q         <= SEG_BLANK;
      dig_en_q      <= '0;
    end else begin
      pre_q <= pre_q + DIV_LOG2'(1);
      if (pre_q == '1) begin
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      end
      pending_q     <= pending_d;
      shown_q       <= shown_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      seg_q         <= seg_d;
      dig_en_q      <= dig_en_d;
    end
  end

  assign load.load_ready = !pending_q;
  assign seg             = seg_q;
  assign dig_en          = dig_en_q;
  assign frame_tick      = frame_end;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised bench for seg_scan_driver: HEX7 and INDEX instances share stimulus and are
// compared every cycle against a frame-level reference model.
module tb_seg_scan_driver;

  localparam int unsigned DIGITS   = 4;
  localparam int unsigned DIV_LOG2 = 4;
  localparam int unsigned SLOT     = 1 << DIV_LOG2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] brightness;
  logic [7:0] seg0, seg1;
  logic [3:0] den0, den1;
  logic       ft0, ft1;

  int checks = 0;
  int failures = 0;

  seg_scan_driver_if #(.DIGITS(DIGITS)) lif0 ();
  seg_scan_driver_if #(.DIGITS(DIGITS)) lif1 ();

  seg_scan_driver #(.DIGITS(DIGITS), .DIV_LOG2(DIV_LOG2), .MODE(0)) u_dut_hex (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lif0.slave),
    .brightness (brightness),
    .seg        (seg0),
    .dig_en     (den0),
    .frame_tick (ft0)
  );

  seg_scan_driver #(.DIGITS(DIGITS), .DIV_LOG2(DIV_LOG2), .MODE(1)) u_dut_idx (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lif1.slave),
    .brightness (brightness),
    .seg        (seg1),
    .dig_en     (den1),
    .frame_tick (ft1)
  );

  always #5 clk = ~clk;

  // Reference state: time since reset plus the two frame buffers.
  int        m_t;
  bit        m_pending, m_shown;
  bit [15:0] m_shadow, m_active;
  bit [3:0]  m_sdp, m_adp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%0h expected=%0h", tag, m_t, obs, exp);
    end
  endtask

  function automatic bit [7:0] glyph(input int mode, input bit [3:0] n, input bit dp);
    bit [6:0] g;
    if (mode == 1) return {dp, 2'b00, 5'(n) + 5'd1};
    case (n)
      4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
      4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
      4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
      4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
    endcase
    return {dp, g};
  endfunction

  function automatic int cur_pre();
    return m_t % SLOT;
  endfunction

  function automatic int cur_idx();
    return (m_t / SLOT) % DIGITS;
  endfunction

  function automatic bit at_frame_end();
    return (cur_pre() == SLOT - 1) && (cur_idx() == DIGITS - 1);
  endfunction

  task automatic model_reset();
    m_t = 0;  m_pending = 0;  m_shown = 0;
    m_shadow = '0;  m_active = '0;  m_sdp = '0;  m_adp = '0;
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_seg_hex"}, 32'(seg0), 32'h0);
    check({tag, "_seg_idx"}, 32'(seg1), 32'h0);
    check({tag, "_den_hex"}, 32'(den0), 32'h0);
    check({tag, "_den_idx"}, 32'(den1), 32'h0);
    check({tag, "_tick"},    32'(ft0 | ft1), 32'h0);
    check({tag, "_ready"},   32'(lif0.load_ready & lif1.load_ready), 32'h1);
  endtask

  // One clock, entered and left at a falling edge.
  task automatic cycle(input bit v, input bit [15:0] d, input bit [3:0] dp, input bit [3:0] br,
                       output bit accepted);
    int        idx, pre;
    bit        fe;
    bit [7:0]  e_seg0, e_seg1;
    bit [3:0]  e_den;
    lif0.load_valid = v;  lif0.load_data = d;  lif0.load_dp = dp;
    lif1.load_valid = v;  lif1.load_data = d;  lif1.load_dp = dp;
    brightness = br;
    idx = cur_idx();
    pre = cur_pre();
    fe  = at_frame_end();
    check("frame_tick_hex", 32'(ft0), 32'(fe));
    check("frame_tick_idx", 32'(ft1), 32'(fe));
    check("load_ready_hex", 32'(lif0.load_ready), 32'(!m_pending));
    check("load_ready_idx", 32'(lif1.load_ready), 32'(!m_pending));
    e_seg0 = m_shown ? glyph(0, m_active[idx*4 +: 4], m_adp[idx]) : 8'h00;
    e_seg1 = m_shown ? glyph(1, m_active[idx*4 +: 4], m_adp[idx]) : 8'h00;
    e_den  = (m_shown && (pre >> (DIV_LOG2 - 4)) <= int'(br)) ? 4'(1 << idx) : 4'h0;
    accepted = v && !m_pending;
    if (fe && m_pending) begin
      m_active = m_shadow;  m_adp = m_sdp;  m_pending = 0;  m_shown = 1;
    end else if (accepted) begin
      m_shadow = d;  m_sdp = dp;  m_pending = 1;
    end
    m_t++;
    @(posedge clk);
    #1;
    check("seg_hex",    32'(seg0), 32'(e_seg0));
    check("seg_idx",    32'(seg1), 32'(e_seg1));
    check("dig_en_hex", 32'(den0), 32'(e_den));
    check("dig_en_idx", 32'(den1), 32'(e_den));
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit [3:0] br);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 4'($urandom), br, acc);
  endtask

  task automatic send(input bit [15:0] d, input bit [3:0] dp, input bit [3:0] br);
    bit acc;
    acc = 0;
    for (int i = 0; i < 200 && !acc; i++) cycle(1'b1, d, dp, br, acc);
    check("send_accepted", 32'(acc), 32'h1);
  endtask

  task automatic idle_until(input int pre, input int idx, input bit [3:0] br);
    bit acc;
    for (int i = 0; i < 200 && !(cur_pre() == pre && cur_idx() == idx); i++)
      cycle(1'b0, '0, '0, br, acc);
  endtask

  initial begin
    bit acc;
    lif0.load_valid = 0;  lif0.load_data = '0;  lif0.load_dp = '0;
    lif1.load_valid = 0;  lif1.load_data = '0;  lif1.load_dp = '0;
    brightness = 4'hF;
    model_reset();
    #1;
    check_blank("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // No load yet: blank display, periodic frame_tick.
    idle(3 * DIGITS * SLOT, 4'($urandom));

    send(16'h1234, 4'b0001, 4'hF);
    idle(2 * DIGITS * SLOT, 4'hF);

    // Back-to-back loads: second stalls until the first commits.
    send(16'hAAAA, 4'b0000, 4'hF);
    send(16'h5555, 4'b0000, 4'hF);
    idle(3 * DIGITS * SLOT, 4'hF);

    // Transfer exactly in the frame-end cycle is deferred by a full frame.
    idle_until(SLOT - 1, DIGITS - 1, 4'hF);
    cycle(1'b1, 16'h9C3E, 4'b1010, 4'hF, acc);
    check("frame_end_xfer", 32'(acc), 32'h1);
    idle(2 * DIGITS * SLOT, 4'hF);

    idle(DIGITS * SLOT, 4'd3);
    idle(DIGITS * SLOT, 4'd15);

    send(16'hF0F0, 4'b0110, 4'hF);
    for (int i = 0; i < 1500; i++)
      cycle(($urandom % 4) == 0, 16'($urandom), 4'($urandom), 4'($urandom), acc);

    // Asynchronous reset mid-frame, then blank until the next commit.
    idle(2 * DIGITS * SLOT, 4'hF);
    idle_until(7, 1, 4'hF);
    send(16'h0123, 4'b1111, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    check_blank("async_reset");
    @(negedge clk);
    check_blank("reset_held");
    model_reset();
    rst_n = 1'b1;
    idle(2 * DIGITS * SLOT, 4'hF);
    send(16'h8E4B, 4'b0101, 4'($urandom));
    idle(2 * DIGITS * SLOT, 4'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
